// File: rtl/mux_pkg.sv
// Shared types and defaults for the registered 2:1 selector.
package mux_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } mux_sel_e;

endpackage

// File: rtl/mux2_core.sv
// Pure combinational WIDTH-bit 2:1 selector.
module mux2_core
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    output logic [WIDTH-1:0] y_o
);

    mux_sel_e sel;

    assign sel = mux_sel_e'(sel_i);
    // Ternary lets an unknown select show up as X on the output.
    assign y_o = (sel == SEL_IN1) ? in1_i : in0_i;

endmodule

// File: rtl/mux2_sel_reg.sv
// 2:1 selector with combinational and registered outputs, plus select-change
// pulse and a saturating select-switch counter.
module mux2_sel_reg
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selectCase,
    input  logic [WIDTH-1:0] value0,
    input  logic [WIDTH-1:0] value1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             out_vld,
    output logic             sel_changed,
    output logic [CNT_W-1:0] switch_cnt
);

    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] data_d, data_q;
    logic             vld_d, vld_q;
    logic             sel_prev_d, sel_prev_q;
    logic             changed_d, changed_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    mux2_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .sel_i (selectCase),
        .in0_i (value0),
        .in1_i (value1),
        .y_o   (mux_out)
    );

    always_comb begin
        data_d     = mux_out;
        vld_d      = 1'b1;
        sel_prev_d = selectCase;
        changed_d  = (selectCase != sel_prev_q);
        cnt_d      = cnt_q;
        // Saturate at all-ones rather than wrapping.
        if (changed_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q     <= '0;
            vld_q      <= 1'b0;
            sel_prev_q <= 1'b0;
            changed_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            data_q     <= data_d;
            vld_q      <= vld_d;
            sel_prev_q <= sel_prev_d;
            changed_q  <= changed_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out         = mux_out;
    assign out_q       = data_q;
    assign out_vld     = vld_q;
    assign sel_changed = changed_q;
    assign switch_cnt  = cnt_q;

endmodule

// File: tb/tb_mux2_sel_reg.sv
// Directed bench for mux2_sel_reg with a scoreboard of registered results.
module tb_mux2_sel_reg;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [3:0]  v0, v1;
    logic [3:0]  out, out_q;
    logic        out_vld, sel_changed;
    logic [7:0]  switch_cnt;

    logic        sel32;
    logic [31:0] w0, w1, out32, out32_q;
    logic        vld32, chg32;
    logic [7:0]  cnt32;

    int n_asserts = 0;
    int n_fails   = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       vld;
        logic       chg;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic       m_prev;
    logic [7:0] m_cnt;

    mux2_sel_reg #(
        .WIDTH (4),
        .CNT_W (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .selectCase  (sel),
        .value0      (v0),
        .value1      (v1),
        .out         (out),
        .out_q       (out_q),
        .out_vld     (out_vld),
        .sel_changed (sel_changed),
        .switch_cnt  (switch_cnt)
    );

    mux2_sel_reg #(
        .WIDTH (32),
        .CNT_W (8)
    ) u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .selectCase  (sel32),
        .value0      (w0),
        .value1      (w1),
        .out         (out32),
        .out_q       (out32_q),
        .out_vld     (vld32),
        .sel_changed (chg32),
        .switch_cnt  (cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one set of inputs, check the combinational path, then check the
    // registered result one edge later against the scoreboard.
    task automatic step(input logic s, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        exp_t got;
        sel = s;
        v0  = a;
        v1  = b;
        #1;
        check("out_comb", {28'd0, out}, {28'd0, (s ? b : a)});
        e.data = s ? b : a;
        e.vld  = 1'b1;
        e.chg  = (s != m_prev);
        if (e.chg && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        e.cnt  = m_cnt;
        m_prev = s;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb.pop_front();
            check("out_q", {28'd0, out_q}, {28'd0, got.data});
            check("out_vld", {31'd0, out_vld}, {31'd0, got.vld});
            check("sel_changed", {31'd0, sel_changed}, {31'd0, got.chg});
            check("switch_cnt", {24'd0, switch_cnt}, {24'd0, got.cnt});
        end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        sel   = 1'b0;
        v0    = 4'b1111;
        v1    = 4'b0000;
        sel32 = 1'b0;
        w0    = 32'h0;
        w1    = 32'h0;
        m_prev = 1'b0;
        m_cnt  = 8'd0;
        #3;
        check("rst_out_q", {28'd0, out_q}, 32'd0);
        check("rst_vld", {31'd0, out_vld}, 32'd0);
        check("rst_chg", {31'd0, sel_changed}, 32'd0);
        check("rst_cnt", {24'd0, switch_cnt}, 32'd0);
        check("rst_out", {28'd0, out}, 32'hF);

        @(negedge clk);
        rst = 1'b0;

        step(1'b0, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b1010);
        step(1'b0, 4'b0101, 4'b1010);
        step(1'b1, 4'b0011, 4'b0110);
        step(1'b1, 4'b0011, 4'b0000);

        // Async reset between edges: out_q is 0000 and switch_cnt is nonzero.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_q", {28'd0, out_q}, 32'd0);
        check("arst_vld", {31'd0, out_vld}, 32'd0);
        check("arst_chg", {31'd0, sel_changed}, 32'd0);
        check("arst_cnt", {24'd0, switch_cnt}, 32'd0);
        v1 = 4'b1001;
        #1;
        check("arst_out", {28'd0, out}, 32'h9);
        @(negedge clk);
        rst    = 1'b0;
        m_prev = 1'b0;
        m_cnt  = 8'd0;

        for (int i = 0; i < 300; i++) begin
            step(~m_prev, 4'($urandom), 4'($urandom));
        end
        check("sat_cnt", {24'd0, switch_cnt}, 32'd255);

        sel32 = 1'b1;
        w0    = 32'hFFFFFFF1;
        w1    = 32'h11111111;
        #1;
        check("w32_out", out32, 32'h11111111);
        @(posedge clk);
        #1;
        check("w32_out_q", out32_q, 32'h11111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
